arbiter8_rr: RTL and testbench

Round-robin arbiter that shares one resource (bus, display slot, peripheral port) between 8 requesters. It resolves a 3-bit owner index and drives the one-hot grant vector from that index in 3-to-8 decoder encoding. Grants are locking, with a bounded hold time and a mandatory one-cycle break-before-make gap between owners. It sits between the requesting blocks and the shared resource's select/enable inputs.

---
 rtl/arbiter8_rr_if.sv | 18 +
 rtl/arbiter8_rr.sv | 136 +++++++++++++
 tb/tb_arbiter8_rr.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/arbiter8_rr_if.sv
// arbiter8_rr_if - request/grant bundle between the requesters and the
// round-robin arbiter.
//   req          8  request lines, driven by the requesters
//   grant        8  one-hot grant, driven by the arbiter
//   grant_idx    3  index of the current (or last) owner
//   grant_valid  1  high while some requester owns the resource
//   timeout      1  one-cycle pulse after a forced release
// master: requester side; slave: arbiter side.
interface arbiter8_rr_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (output req, input grant, grant_idx, grant_valid, timeout);
  modport slave  (input req, output grant, grant_idx, grant_valid, timeout);
endinterface

// File: rtl/arbiter8_rr.sv
// arbiter8_rr - 8-way locking round-robin arbiter with bounded hold time and
// a one-cycle break-before-make gap between owners.
//   MAX_HOLD  maximum consecutive grant cycles per ownership, 0 = unlimited
//   clk       clock, all state changes on the rising edge
//   rst       asynchronous active-high reset
//   bus       arbiter8_rr_if.slave: req in; grant, grant_idx, grant_valid,
//             timeout out (all outputs registered)
module arbiter8_rr #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  arbiter8_rr_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam bit         HOLD_EN    = (MAX_HOLD != 0);

  state_t     state_r, state_s;
  logic [2:0] ptr_r, ptr_s;
  logic [7:0] hcnt_r, hcnt_s;
  logic [7:0] grant_r, grant_s;
  logic [2:0] idx_r, idx_s;
  logic       valid_r, valid_s;
  logic       timeout_r, timeout_s;
  logic [3:0] pick_s;

  // Circular priority search starting at p. Offsets are visited from the
  // farthest back to p itself so the nearest requester is the last writer.
  // Returns {found, index}.
  function automatic logic [3:0] arb_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] j;
    res = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      j = p + 3'(k);
      if (r[j]) begin
        res = {1'b1, j};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Arbitration result for the current pointer, used in IDLE and GAP.
  always_comb begin
    pick_s = arb_pick(bus.req, ptr_r);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    hcnt_s    = hcnt_r;
    grant_s   = grant_r;
    idx_s     = idx_r;
    valid_s   = valid_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE, GAP: begin
        if (pick_s[3]) begin
          state_s = GRANT;
          idx_s   = pick_s[2:0];
          grant_s = 8'b0000_0001 << pick_s[2:0];
          valid_s = 1'b1;
          hcnt_s  = 8'd1;
        end else begin
          state_s = IDLE;
          grant_s = 8'h00;
          valid_s = 1'b0;
        end
      end
      GRANT: begin
        if (!bus.req[idx_r]) begin
          state_s = GAP;
          grant_s = 8'h00;
          valid_s = 1'b0;
          ptr_s   = idx_r + 3'd1;
        end else if (HOLD_EN && (hcnt_r == HOLD_LIMIT)) begin
          // Forced release: the pre-empted owner goes to the back of the queue.
          state_s   = GAP;
          grant_s   = 8'h00;
          valid_s   = 1'b0;
          ptr_s     = idx_r + 3'd1;
          timeout_s = 1'b1;
        end else begin
          // Saturating count only matters for unlimited hold.
          if (hcnt_r != 8'hFF) begin
            hcnt_s = hcnt_r + 8'd1;
          end else begin
            hcnt_s = hcnt_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = 8'h00;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= 3'd0;
      hcnt_r    <= 8'd0;
      grant_r   <= 8'h00;
      idx_r     <= 3'd0;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      hcnt_r    <= hcnt_s;
      grant_r   <= grant_s;
      idx_r     <= idx_s;
      valid_r   <= valid_s;
      timeout_r <= timeout_s;
    end
  end

  assign bus.grant       = grant_r;
  assign bus.grant_idx   = idx_r;
  assign bus.grant_valid = valid_r;
  assign bus.timeout     = timeout_r;

endmodule

// File: tb/tb_arbiter8_rr.sv
// tb_arbiter8_rr - three arbiters (MAX_HOLD 16, 4, 0) driven by directed and
// random request patterns; an ownership-level model predicts every output on
// every cycle, and directed scenarios pin literal expectations.
module tb_arbiter8_rr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  arbiter8_rr_if ifa ();
  arbiter8_rr_if ifb ();
  arbiter8_rr_if ifc ();

  arbiter8_rr #(.MAX_HOLD(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  arbiter8_rr #(.MAX_HOLD(4))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  arbiter8_rr #(.MAX_HOLD(0))  dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  always #5 clk = ~clk;

  // Model: who owns the resource, for how long, and who owned it last.
  int   mh[3]      = '{16, 4, 0};
  int   owner[3]   = '{-1, -1, -1};
  int   held[3]    = '{0, 0, 0};
  int   lastown[3] = '{7, 7, 7};
  int   idx_e[3]   = '{0, 0, 0};
  bit   to_e[3]    = '{1'b0, 1'b0, 1'b0};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] get_req(input int k);
    if (k == 0) return ifa.req;
    else if (k == 1) return ifb.req;
    else return ifc.req;
  endfunction

  task automatic m_reset(input int k);
    owner[k] = -1; held[k] = 0; lastown[k] = 7; idx_e[k] = 0; to_e[k] = 1'b0;
  endtask

  task automatic m_step(input int k);
    logic [7:0] r;
    r = get_req(k);
    to_e[k] = 1'b0;
    if (owner[k] >= 0) begin
      if (!r[owner[k]] || (mh[k] != 0 && held[k] == mh[k])) begin
        to_e[k]    = r[owner[k]];   // still requesting -> it was forced out
        lastown[k] = owner[k];
        owner[k]   = -1;
      end else begin
        held[k]++;
      end
    end else begin
      for (int s = 1; s <= 8; s++) begin
        int j;
        j = (lastown[k] + s) % 8;
        if (r[j]) begin
          owner[k] = j; idx_e[k] = j; held[k] = 1;
          break;
        end
      end
    end
  endtask

  task automatic m_compare(input int k);
    logic [7:0] g, gi, gv, t, eg;
    string n;
    n = (k == 0) ? "a" : (k == 1) ? "b" : "c";
    if (k == 0) begin g = ifa.grant; gi = 8'(ifa.grant_idx); gv = 8'(ifa.grant_valid); t = 8'(ifa.timeout); end
    else if (k == 1) begin g = ifb.grant; gi = 8'(ifb.grant_idx); gv = 8'(ifb.grant_valid); t = 8'(ifb.timeout); end
    else begin g = ifc.grant; gi = 8'(ifc.grant_idx); gv = 8'(ifc.grant_valid); t = 8'(ifc.timeout); end
    eg = (owner[k] >= 0) ? (8'h01 << owner[k]) : 8'h00;
    chk({"model grant ", n}, g, eg);
    chk({"model grant_idx ", n}, gi, 8'(idx_e[k]));
    chk({"model grant_valid ", n}, gv, (owner[k] >= 0) ? 8'h01 : 8'h00);
    chk({"model timeout ", n}, t, to_e[k] ? 8'h01 : 8'h00);
  endtask

  // Advance the model at each edge (or async reset) and check all outputs
  // shortly afterwards.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) m_reset(k);
      else m_step(k);
    end
    #2;
    for (int k = 0; k < 3; k++) m_compare(k);
  end

  initial begin
    ifa.req = 8'hFF; ifb.req = 8'hFF; ifc.req = 8'hFF;

    // Reset with all requests high.
    @(negedge clk);
    chk("rst grant", ifa.grant, 8'h00);
    chk("rst grant_idx", 8'(ifa.grant_idx), 8'h00);
    chk("rst grant_valid", 8'(ifa.grant_valid), 8'h00);
    chk("rst timeout", 8'(ifa.timeout), 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("first grant a", ifa.grant, 8'h01);
    chk("first grant b", ifb.grant, 8'h01);
    ifa.req = 8'h00; ifc.req = 8'h00;

    // Saturation rotation on b (MAX_HOLD=4): 4 grant cycles then 1 gap.
    for (int cyc = 0; cyc < 45; cyc++) begin
      logic [7:0] eg;
      if (cyc != 0) @(negedge clk);
      eg = ((cyc % 5) < 4) ? (8'h01 << ((cyc / 5) % 8)) : 8'h00;
      chk("rot grant", ifb.grant, eg);
      chk("rot timeout", 8'(ifb.timeout), ((cyc % 5) == 4) ? 8'h01 : 8'h00);
    end
    ifb.req = 8'h00;
    repeat (3) @(negedge clk);

    // Single requester 3 on a for 5 cycles.
    ifa.req = 8'h08;
    repeat (5) begin
      @(negedge clk);
      chk("single grant", ifa.grant, 8'h08);
      chk("single idx", 8'(ifa.grant_idx), 8'h03);
      chk("single timeout", 8'(ifa.timeout), 8'h00);
    end
    ifa.req = 8'h00;
    @(negedge clk);
    chk("single gap grant", ifa.grant, 8'h00);
    chk("single gap timeout", 8'(ifa.timeout), 8'h00);
    @(negedge clk);
    chk("single idle grant", ifa.grant, 8'h00);
    chk("single idle idx", 8'(ifa.grant_idx), 8'h03);

    // Fairness: 5 owns, 2 and 6 arrive; 6 then 2 follow.
    ifa.req = 8'h20;
    @(negedge clk);
    chk("fair own5", ifa.grant, 8'h20);
    ifa.req = 8'h64;
    repeat (2) @(negedge clk);
    chk("fair hold5", ifa.grant, 8'h20);
    ifa.req = 8'h44;
    @(negedge clk);
    chk("fair gap1", ifa.grant, 8'h00);
    @(negedge clk);
    chk("fair own6", ifa.grant, 8'h40);
    ifa.req = 8'h04;
    @(negedge clk);
    chk("fair gap2", ifa.grant, 8'h00);
    @(negedge clk);
    chk("fair own2", ifa.grant, 8'h04);
    ifa.req = 8'h00;
    repeat (2) @(negedge clk);

    // Reset mid-grant on c: outputs clear with no clock edge.
    ifc.req = 8'h40;
    @(negedge clk);
    chk("mid own6", ifc.grant, 8'h40);
    #2 rst = 1'b1;
    #1;
    chk("mid rst grant", ifc.grant, 8'h00);
    chk("mid rst valid", 8'(ifc.grant_valid), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    ifc.req = 8'h81;
    @(negedge clk);
    chk("mid restart", ifc.grant, 8'h01);

    // Unlimited hold on c: requester 7 for 300 cycles.
    ifc.req = 8'h80;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk("unlim grant", ifc.grant, 8'h80);
      chk("unlim timeout", 8'(ifc.timeout), 8'h00);
    end
    ifc.req = 8'h00;
    repeat (2) @(negedge clk);

    // Random traffic, requests tend to persist for a few cycles.
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) ifa.req = 8'($urandom);
      if ($urandom_range(3) == 0) ifb.req = 8'($urandom);
      if ($urandom_range(7) == 0) ifc.req = 8'($urandom);
    end
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
